// File: rtl/scope_frame_decoder.sv
// Receive side of the 8-bit scope link: debounces the slot-multiplexed byte stream,
// classifies SYNC run lengths, and recovers id/x/y frames into a per-object table.
module scope_frame_decoder #(
    parameter int SLOT_CYCLES = 1048576,
    parameter int MIN_STABLE  = 4,
    parameter int CNT_W       = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic [2:0] rd_sel,
    output logic [2:0] obj_id,
    output logic [6:0] x_pos,
    output logic [5:0] y_pos,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       locked,
    output logic [6:0] rd_x,
    output logic [5:0] rd_y,
    output logic       rd_seen
);

    localparam logic [7:0]       SYNC     = 8'hC0;
    localparam int               STB_W    = (MIN_STABLE > 1) ? $clog2(MIN_STABLE) : 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(MIN_STABLE - 1);
    localparam logic [CNT_W-1:0] RUN_SAT  = CNT_W'(4 * SLOT_CYCLES);
    localparam logic [CNT_W-1:0] RUN_PRE  = CNT_W'(4 * SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MIN = CNT_W'(2 * SLOT_CYCLES);

    typedef enum logic [1:0] {
        HUNT,
        EXP_ID,
        EXP_X,
        EXP_Y
    } state_t;

    logic [7:0]       din_q;
    logic [7:0]       cur_sym;
    logic [7:0]       cand_sym;
    logic [STB_W-1:0] stable_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic             cand_match;
    logic             accept;

    logic             acc_evt;
    logic [7:0]       acc_sym;
    logic [7:0]       acc_prev;
    logic [CNT_W-1:0] acc_len;
    logic             sat_evt;

    logic             is_data;
    logic             is_short;
    logic             is_long;
    logic             data_to_data;

    state_t           state;
    state_t           state_next;
    logic             have_id;
    logic             have_id_next;
    logic [2:0]       id_reg;
    logic [2:0]       id_next;
    logic [6:0]       x_reg;
    logic [6:0]       x_next;
    logic             valid_next;
    logic             error_next;
    logic             tbl_we;

    logic [6:0]       tbl_x [8];
    logic [5:0]       tbl_y [8];
    logic [7:0]       seen;

    // A candidate byte must differ from the current symbol and stay identical to
    // itself for MIN_STABLE cycles; any other value restarts or clears the count.
    always_comb begin
        cand_match = (stable_cnt == '0) || (din_q == cand_sym);
        accept     = (din_q != cur_sym) && cand_match && (stable_cnt == STB_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            din_q      <= SYNC;
            cur_sym    <= SYNC;
            cand_sym   <= SYNC;
            stable_cnt <= '0;
            run_cnt    <= '0;
            acc_evt    <= 1'b0;
            acc_sym    <= SYNC;
            acc_prev   <= SYNC;
            acc_len    <= '0;
            sat_evt    <= 1'b0;
        end else begin
            din_q   <= din;
            acc_evt <= accept;
            sat_evt <= !accept && (run_cnt == RUN_PRE);
            if (accept) begin
                cur_sym    <= din_q;
                acc_sym    <= din_q;
                acc_prev   <= cur_sym;
                acc_len    <= run_cnt;
                run_cnt    <= CNT_W'(1);
                stable_cnt <= '0;
            end else begin
                if (run_cnt != RUN_SAT) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
                if (din_q == cur_sym) begin
                    stable_cnt <= '0;
                end else if (cand_match) begin
                    cand_sym   <= din_q;
                    stable_cnt <= stable_cnt + STB_W'(1);
                end else begin
                    cand_sym   <= din_q;
                    stable_cnt <= STB_W'(1);
                end
            end
        end
    end

    // The length captured with a data symbol is that of the SYNC run before it.
    always_comb begin
        is_data      = (acc_sym != SYNC);
        is_short     = (acc_len < LONG_MIN);
        is_long      = (acc_len >= LONG_MIN) && (acc_len < RUN_SAT);
        data_to_data = is_data && (acc_prev != SYNC);
    end

    always_comb begin
        state_next   = state;
        have_id_next = have_id;
        id_next      = id_reg;
        x_next       = x_reg;
        valid_next   = 1'b0;
        error_next   = 1'b0;
        tbl_we       = 1'b0;
        if (state == HUNT) begin
            // Acquisition: remember an id-shaped byte, then lock on the X after a long run.
            if (acc_evt && is_data) begin
                if (data_to_data) begin
                    have_id_next = 1'b0;
                end else if (is_long && have_id && !acc_sym[7]) begin
                    x_next     = acc_sym[6:0];
                    state_next = EXP_Y;
                end else if (acc_sym[7:3] == 5'd0) begin
                    id_next      = acc_sym[2:0];
                    have_id_next = 1'b1;
                end else begin
                    have_id_next = 1'b0;
                end
            end
        end else if (sat_evt) begin
            error_next = 1'b1;
        end else if (acc_evt && is_data) begin
            if (data_to_data) begin
                error_next = 1'b1;
            end else begin
                case (state)
                    EXP_ID: begin
                        if (is_short && (acc_sym[7:3] == 5'd0)) begin
                            id_next    = acc_sym[2:0];
                            state_next = EXP_X;
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                    EXP_X: begin
                        if (is_long && !acc_sym[7]) begin
                            x_next     = acc_sym[6:0];
                            state_next = EXP_Y;
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                    EXP_Y: begin
                        if (is_short && (acc_sym[7:6] == 2'd0)) begin
                            valid_next = 1'b1;
                            tbl_we     = 1'b1;
                            state_next = EXP_ID;
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                    default: begin
                        error_next = 1'b1;
                    end
                endcase
            end
        end
        if (error_next) begin
            state_next   = HUNT;
            have_id_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            have_id     <= 1'b0;
            id_reg      <= 3'd0;
            x_reg       <= 7'd0;
            obj_id      <= 3'd0;
            x_pos       <= 7'd0;
            y_pos       <= 6'd0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            have_id     <= have_id_next;
            id_reg      <= id_next;
            x_reg       <= x_next;
            frame_valid <= valid_next;
            frame_error <= error_next;
            locked      <= (state_next != HUNT);
            if (valid_next) begin
                obj_id <= id_reg;
                x_pos  <= x_reg;
                y_pos  <= acc_sym[5:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                tbl_x[i] <= 7'd0;
                tbl_y[i] <= 6'd0;
            end
            seen <= 8'd0;
        end else if (tbl_we) begin
            tbl_x[id_reg] <= x_reg;
            tbl_y[id_reg] <= acc_sym[5:0];
            seen[id_reg]  <= 1'b1;
        end
    end

    assign rd_x    = tbl_x[rd_sel];
    assign rd_y    = tbl_y[rd_sel];
    assign rd_seen = seen[rd_sel];

endmodule

// File: tb/tb_scope_frame_decoder.sv
// Randomized bench for scope_frame_decoder: a symbol-level model predicts frame and
// error strobes into a queue; a negedge monitor pops and compares each DUT strobe.
module tb_scope_frame_decoder;

    localparam int         SLOT = 16;
    localparam int         MINS = 4;
    localparam int         LAT  = MINS + 2;
    localparam int         SAT  = 4 * SLOT;
    localparam logic [7:0] SYNC = 8'hC0;
    localparam int         M_HUNT = 0;
    localparam int         M_ID   = 1;
    localparam int         M_X    = 2;
    localparam int         M_Y    = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [2:0] rd_sel;
    logic [2:0] obj_id;
    logic [6:0] x_pos;
    logic [5:0] y_pos;
    logic       frame_valid;
    logic       frame_error;
    logic       locked;
    logic [6:0] rd_x;
    logic [5:0] rd_y;
    logic       rd_seen;

    scope_frame_decoder #(
        .SLOT_CYCLES(SLOT),
        .MIN_STABLE (MINS),
        .CNT_W      (24)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .rd_sel     (rd_sel),
        .obj_id     (obj_id),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .locked     (locked),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_seen    (rd_seen)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_err;
        int id;
        int x;
        int y;
        int t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int         m_state;
    bit         m_have_id;
    int         m_id;
    int         m_x;
    int         m_tbl_x [8];
    int         m_tbl_y [8];
    int         m_seen  [8];
    logic [7:0] m_cur;
    int         m_run;
    int         m_out_id;
    int         m_out_x;
    int         m_out_y;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void model_reset();
        m_state   = M_HUNT;
        m_have_id = 1'b0;
        m_id      = 0;
        m_x       = 0;
        m_cur     = SYNC;
        m_run     = 0;
        m_out_id  = 0;
        m_out_x   = 0;
        m_out_y   = 0;
        for (int i = 0; i < 8; i++) begin
            m_tbl_x[i] = 0;
            m_tbl_y[i] = 0;
            m_seen[i]  = 0;
        end
    endfunction

    function automatic void push_event(input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.id     = m_out_id;
        e.x      = m_out_x;
        e.y      = m_out_y;
        e.t      = cyc + LAT;
        exp_q.push_back(e);
    endfunction

    function automatic void model_error();
        push_event(1'b1);
        m_state   = M_HUNT;
        m_have_id = 1'b0;
    endfunction

    // Protocol rules applied to one accepted data byte and the run that preceded it.
    function automatic void model_symbol(input logic [7:0] b, input int prev_len, input logic [7:0] prev_sym);
        bit short_run;
        bit long_run;
        bit d2d;
        short_run = (prev_len < 2 * SLOT);
        long_run  = (prev_len >= 2 * SLOT) && (prev_len < SAT);
        d2d       = (prev_sym != SYNC);
        if (b == SYNC) return;
        if (m_state == M_HUNT) begin
            if (d2d) m_have_id = 1'b0;
            else if (long_run && m_have_id && b < 128) begin
                m_x     = b;
                m_state = M_Y;
            end else if (b < 8) begin
                m_id      = b;
                m_have_id = 1'b1;
            end else m_have_id = 1'b0;
        end else if (d2d) begin
            model_error();
        end else if (m_state == M_ID) begin
            if (short_run && b < 8) begin
                m_id    = b;
                m_state = M_X;
            end else model_error();
        end else if (m_state == M_X) begin
            if (long_run && b < 128) begin
                m_x     = b;
                m_state = M_Y;
            end else model_error();
        end else begin
            if (short_run && b < 64) begin
                m_out_id        = m_id;
                m_out_x         = m_x;
                m_out_y         = b;
                m_tbl_x[m_id]   = m_x;
                m_tbl_y[m_id]   = b;
                m_seen[m_id]    = 1;
                push_event(1'b0);
                m_state         = M_ID;
            end else model_error();
        end
    endfunction

    task automatic drive_cycle(input logic [7:0] drv, input logic [7:0] sym, input bit rst);
        @(posedge clock);
        #1;
        din   = drv;
        reset = rst;
        if (rst) begin
            check_output("queue_empty_at_reset", exp_q.size(), 0);
            model_reset();
            return;
        end
        if (sym != m_cur) begin
            model_symbol(sym, m_run, m_cur);
            m_cur = sym;
            m_run = 0;
        end
        if (m_run < SAT) begin
            m_run++;
            if (m_run == SAT && m_state != M_HUNT) model_error();
        end
    endtask

    task automatic send_slot(input logic [7:0] b, input int glitch_at, input bit readback, input int reset_at);
        logic [7:0] drv;
        for (int i = 0; i < SLOT; i++) begin
            drv = (glitch_at >= 0 && (i == glitch_at || i == glitch_at + 1)) ? 8'hFF : b;
            drive_cycle(drv, b, i == reset_at);
            if (reset_at >= 0 && i == reset_at + 1) begin
                @(negedge clock);
                check_output("reset_obj_id", obj_id, 0);
                check_output("reset_x_pos", x_pos, 0);
                check_output("reset_y_pos", y_pos, 0);
                check_output("reset_locked", locked, 0);
                check_output("reset_frame_valid", frame_valid, 0);
            end
            if (readback && i >= SLOT - 8) begin
                rd_sel = 3'(i - (SLOT - 8));
                @(negedge clock);
                check_output($sformatf("rd_seen[%0d]", rd_sel), rd_seen, m_seen[rd_sel]);
                check_output($sformatf("rd_x[%0d]", rd_sel), rd_x, m_tbl_x[rd_sel]);
                check_output($sformatf("rd_y[%0d]", rd_sel), rd_y, m_tbl_y[rd_sel]);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] id_b, input logic [7:0] x_b, input logic [7:0] y_b,
                              input int glitch_slot, input bit readback, input bit reset_mid, input bit drop_xy);
        logic [7:0] slots [8];
        int         g;
        slots = '{SYNC, id_b, SYNC, SYNC, SYNC, x_b, SYNC, y_b};
        if (drop_xy) begin
            slots[5] = SYNC;
            slots[7] = SYNC;
        end
        for (int s = 0; s < 8; s++) begin
            g = (s == glitch_slot) ? int'($urandom_range(6, 10)) : -1;
            send_slot(slots[s], g, (readback && s == 0) || (reset_mid && s == 6), (reset_mid && s == 6) ? 1 : -1);
        end
    endtask

    task automatic send_random_frame(input bit readback);
        int gsel [4];
        int g;
        gsel = '{2, 3, 4, 6};
        g    = ($urandom_range(0, 1) == 1) ? gsel[$urandom_range(0, 3)] : -1;
        send_frame(8'($urandom_range(0, 7)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 63)),
                   g, readback, 1'b0, 1'b0);
    endtask

    task automatic apply_stimulus();
        int gsel [4];
        gsel = '{2, 3, 4, 6};
        for (int i = 0; i < 3; i++) drive_cycle(SYNC, SYNC, 1'b1);
        for (int i = 0; i < 5; i++) send_slot(SYNC, -1, 1'b0, -1);
        $display("[TB] fixed frames id=3 x=46 y=50");
        for (int f = 0; f < 4; f++) send_frame(8'd3, 8'd46, 8'd50, -1, 1'b0, 1'b0, 1'b0);
        send_frame(8'd3, 8'd46, 8'd50, -1, 1'b1, 1'b0, 1'b0);
        $display("[TB] glitches inside SYNC runs");
        for (int f = 0; f < 3; f++) send_frame(8'd3, 8'd46, 8'd50, gsel[$urandom_range(0, 3)], 1'b0, 1'b0, 1'b0);
        $display("[TB] corrupted X slot");
        send_frame(8'd3, 8'h85, 8'd50, -1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) send_frame(8'd3, 8'd46, 8'd50, -1, 1'b0, 1'b0, 1'b0);
        $display("[TB] overlong SYNC run while locked");
        send_frame(8'd3, 8'd46, 8'd50, -1, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) send_frame(8'd3, 8'd46, 8'd50, -1, 1'b0, 1'b0, 1'b0);
        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) send_random_frame(f == 5);
        $display("[TB] reset while waiting for Y");
        send_frame(8'($urandom_range(0, 7)), 8'($urandom_range(0, 127)), 8'd50, -1, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) send_random_frame(f == 2);
        for (int i = 0; i < 7; i++) send_slot(SYNC, -1, 1'b0, -1);
    endtask

    always @(negedge clock) begin
        if (frame_valid === 1'b1 || frame_error === 1'b1) begin
            check_output("valid_error_exclusive", int'(frame_valid && frame_error), 0);
            check_output("strobe_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_output("strobe_is_error", frame_error, mon_e.is_err);
                check_output("strobe_cycle", cyc, mon_e.t);
                check_output("strobe_locked", locked, !mon_e.is_err);
                check_output("obj_id", obj_id, mon_e.id);
                check_output("x_pos", x_pos, mon_e.x);
                check_output("y_pos", y_pos, mon_e.y);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        din    = SYNC;
        rd_sel = 3'd0;
        model_reset();
        apply_stimulus();
        repeat (LAT + 4) @(posedge clock);
        #1;
        check_output("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
